// File: rtl/serial_adder.sv
// serial_adder: multi-cycle bit-serial two's-complement adder, DIGIT bits per cycle
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       ra, rb;
    logic                   a_msb, b_msb, carry;
    logic [CW-1:0]          cnt;
    logic [DIGIT:0]         sum;
    logic [WIDTH+DIGIT-1:0] wide;
    logic [WIDTH-1:0]       y_next;

    assign sum    = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // concatenating before shifting keeps the slice legal even when DIGIT == WIDTH
    assign wide   = {sum[DIGIT-1:0], y};
    assign y_next = wide[WIDTH+DIGIT-1:DIGIT];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        carry <= 1'b0;
                        cnt   <= '0;
                        y     <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    y     <= y_next;
                    ra    <= ra >> DIGIT;
                    rb    <= rb >> DIGIT;
                    carry <= sum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cout  <= sum[DIGIT];
                        ovf   <= (a_msb == b_msb) && (y_next[WIDTH-1] != a_msb);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at DIGIT=1 and DIGIT=4
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n, start, start4;
    logic [15:0] a, b, a4, b4;
    logic        busy, done, cout, ovf;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] y, y4;
    int          n_vec = 0;
    int          n_err = 0;
    int          lat;
    int          seen;

    serial_adder #(.WIDTH(16), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .y(y4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(sel ? done4 : done) && cyc < 40);
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] ey, input logic ec, input logic eo);
        int c;
        issue(va, vb);
        check({tag, " busy"}, busy, 1'b1);
        wait_done(1'b0, c);
        check({tag, " latency"}, c, 16);
        check({tag, " y"}, y, ey);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        a = '0; b = '0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst y", y, 16'h0);
        check("rst cout", cout, 1'b0);
        check("rst ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1 0+0",       16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_op("t2 2+1",       16'h0002, 16'h0001, 16'h0003, 1'b0, 1'b0);
        run_op("t2 1000+333",  16'd1000, 16'd333,  16'd1333, 1'b0, 1'b0);
        run_op("t3 ffff+1",    16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("t3 ffff+fffe", 16'hFFFF, 16'hFFFE, 16'hFFFD, 1'b1, 1'b0);
        run_op("t4 7fff+1",    16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run_op("t4 8000+8000", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        check("t4 done pulse", done, 1'b1);
        @(posedge clk);
        #1;
        check("t4 done one cycle", done, 1'b0);

        issue(16'd5, 16'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 16'd100; b = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat);
        check("t5 ignored y", y, 16'd12);
        issue(16'd250, 16'd1500);
        check("t5 b2b busy", busy, 1'b1);
        wait_done(1'b0, lat);
        check("t5 b2b latency", lat, 16);
        check("t5 b2b y", y, 16'd1750);

        issue(16'd3, 16'd4);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6 rst busy", busy, 1'b0);
        check("t6 rst done", done, 1'b0);
        check("t6 rst y", y, 16'h0);
        check("t6 rst cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("t6 no done", seen, 0);

        @(negedge clk);
        a4 = 16'd2; b4 = 16'd1; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(1'b1, lat);
        check("t6 d4 latency", lat, 4);
        check("t6 d4 y", y4, 16'd3);
        @(negedge clk);
        a4 = 16'd1000; b4 = 16'd333; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(1'b1, lat);
        check("t6 d4 latency2", lat, 4);
        check("t6 d4 y2", y4, 16'd1333);
        check("t6 d4 cout", cout4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
